// File: rtl/se_scrambler_if.sv
// se_scrambler_if: register bus, input push and output push/stop signals of the scrambler
interface se_scrambler_if #(parameter int DW_IN = 8, parameter int DW_OUT = 32, parameter int AW = 12);
  logic write;
  logic [AW-1:0] addr;
  logic [DW_OUT-1:0] wdata;
  logic pushin;
  logic [DW_IN-1:0] datain;
  logic [DW_OUT-1:0] entrophy;
  logic stopin;
  logic pushout;
  logic [DW_OUT-1:0] dataout;
  logic stopout;
  modport master(output write, addr, wdata, pushin, datain, entrophy, stopout, input stopin, pushout, dataout);
  modport slave(input write, addr, wdata, pushin, datain, entrophy, stopout, output stopin, pushout, dataout);
endinterface

// File: rtl/se_scrambler_param.sv
// se_scrambler_param: keyed, rotated, optionally offset word scrambler with a back-pressured output FIFO
module se_scrambler_param #(
  parameter int DW_IN = 8,
  parameter int DW_OUT = 32,
  parameter int AW = 12,
  parameter int NKEYS = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  se_scrambler_if.slave bus
);
  localparam int IW = $clog2(NKEYS);
  localparam int FW = $clog2(FIFO_DEPTH);
  logic [DW_OUT-1:0] key [NKEYS];
  logic [4:0] rot;
  logic mode;
  logic [IW-1:0] idx;
  logic s1_v;
  logic [DW_OUT-1:0] s1_d;
  logic [DW_OUT-1:0] mem [FIFO_DEPTH];
  logic [FW-1:0] rp, wp;
  logic [FW:0] cnt;
  logic accept, pop, fwr;
  logic [DW_OUT-1:0] mix, r, res;
  logic [2*DW_OUT-1:0] dbl;
  always_comb begin
    mix = key[idx] ^ {(DW_OUT/DW_IN){bus.datain}} ^ bus.entrophy;
    dbl = {mix, mix} << (int'(rot) % DW_OUT);
    r = dbl[2*DW_OUT-1:DW_OUT];
    res = mode ? r + DW_OUT'(idx) : r;
  end
  // stage1 counts against FIFO space so an accepted word always has a slot waiting
  assign bus.stopin = ({1'b0, cnt} + (FW+2)'(s1_v)) >= (FW+2)'(FIFO_DEPTH);
  assign bus.pushout = cnt != '0;
  assign bus.dataout = bus.pushout ? mem[rp] : '0;
  assign accept = bus.pushin & ~bus.stopin;
  assign pop = bus.pushout & ~bus.stopout;
  assign fwr = s1_v & ((cnt != (FW+1)'(FIFO_DEPTH)) | pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NKEYS; i++) key[i] <= '0;
      rot <= '0;
      mode <= 1'b0;
      idx <= '0;
      s1_v <= 1'b0;
      s1_d <= '0;
      rp <= '0;
      wp <= '0;
      cnt <= '0;
    end else begin
      if (bus.write && 32'(bus.addr) < NKEYS) key[bus.addr[IW-1:0]] <= bus.wdata;
      if (bus.write && bus.addr == AW'(12'h800)) begin
        rot <= bus.wdata[4:0];
        mode <= bus.wdata[8];
      end
      if (accept) begin
        s1_d <= res;
        idx <= idx + IW'(1);
      end
      s1_v <= accept | (s1_v & ~fwr);
      if (fwr) begin
        mem[wp] <= s1_d;
        wp <= wp + FW'(1);
      end
      if (pop) rp <= rp + FW'(1);
      cnt <= cnt + (FW+1)'(fwr) - (FW+1)'(pop);
    end
  end
endmodule
